phase_monitor: RTL and testbench

PHASE_MONITOR -- requirements
Module: phase_monitor

---
 rtl/phase_monitor.sv | 141 ++++++++++++++
 tb/tb_phase_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/phase_monitor.sv
// Phase monitor: observes a phase sequencer's count and start request, tracks frames,
// counts error-free completed frames and records the first protocol error until cleared.
module phase_monitor #(
  parameter int unsigned FCNT_W  = 8,
  parameter int unsigned LAST_PH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cnt_in,
  input  logic              clr_err,
  output logic [7:0]        phase_oh,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_e;

  localparam logic [2:0] LAST_PH_C = 3'(LAST_PH);
  localparam logic [1:0] CODE_MISMATCH = 2'b01;
  localparam logic [1:0] CODE_ILLEGAL  = 2'b10;

  state_e            state_q, state_d;
  logic [2:0]        prev_cnt_q, prev_cnt_d;
  logic              prev_start_q, prev_start_d;
  logic [7:0]        phase_oh_q, phase_oh_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [2:0] exp_ph;
  logic       illegal;
  logic       mismatch;
  logic       any_err;
  logic [1:0] new_code;

  always_comb begin
    exp_ph = 3'd0;
    if (prev_cnt_q == 3'd0 && prev_start_q) begin
      exp_ph = 3'd1;
    end else if (prev_cnt_q >= 3'd1 && prev_cnt_q < LAST_PH_C) begin
      exp_ph = prev_cnt_q + 3'd1;
    end

    illegal  = (cnt_in > LAST_PH_C);
    mismatch = !illegal && (state_q != RESYNC) && (cnt_in != exp_ph);
    any_err  = illegal || mismatch;
    new_code = illegal ? CODE_ILLEGAL : CODE_MISMATCH;

    state_d      = state_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_err) begin
          state_d = RESYNC;
        end else if (cnt_in == 3'd1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (any_err) begin
          state_d = RESYNC;
        end else if (cnt_in == 3'd0 && prev_cnt_q == LAST_PH_C) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
        end
      end
      RESYNC: begin
        if (cnt_in == 3'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d == RUN);
    prev_cnt_d   = cnt_in;
    prev_start_d = start;

    phase_oh_d = '0;
    if (!illegal) begin
      phase_oh_d[cnt_in] = 1'b1;
    end

    // A new error overwrites the code only when no error is held or it races a clear.
    err_d      = err_q;
    err_code_d = err_code_q;
    if (any_err) begin
      err_d = 1'b1;
      if (!err_q || clr_err) begin
        err_code_d = new_code;
      end
    end else if (clr_err) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_cnt_q   <= '0;
      prev_start_q <= 1'b0;
      phase_oh_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      prev_cnt_q   <= prev_cnt_d;
      prev_start_q <= prev_start_d;
      phase_oh_q   <= phase_oh_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign phase_oh   = phase_oh_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_phase_monitor.sv
// Directed plus random stimulus for phase_monitor, checked against a frame-level reference model;
// a second instance with a 2-bit frame counter exercises counter wrap.
module tb_phase_monitor;

  localparam int LP = 5;

  logic       clk = 1'b0;
  logic       rst, start, clr_err;
  logic [2:0] cnt_in;

  logic [7:0] phase_oh, phase_oh2;
  logic       busy, busy2, frame_done, frame_done2, err, err2;
  logic [7:0] frame_cnt;
  logic [1:0] frame_cnt2;
  logic [1:0] err_code, err_code2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_prev_cnt, m_prev_start, m_frames;
  bit m_in_frame, m_resync;
  int m_oh, m_busy, m_done, m_err, m_code;

  phase_monitor #(.FCNT_W(8), .LAST_PH(LP)) dut (
    .clk(clk), .rst(rst), .start(start), .cnt_in(cnt_in), .clr_err(clr_err),
    .phase_oh(phase_oh), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err(err), .err_code(err_code)
  );

  phase_monitor #(.FCNT_W(2), .LAST_PH(LP)) dut2 (
    .clk(clk), .rst(rst), .start(start), .cnt_in(cnt_in), .clr_err(clr_err),
    .phase_oh(phase_oh2), .busy(busy2), .frame_done(frame_done2),
    .frame_cnt(frame_cnt2), .err(err2), .err_code(err_code2)
  );

  always #5 clk = ~clk;

  function automatic int m_expected();
    if (m_prev_cnt == 0 && m_prev_start != 0) return 1;
    if (m_prev_cnt >= 1 && m_prev_cnt < LP) return m_prev_cnt + 1;
    return 0;
  endfunction

  task automatic model_update(input int r, input int s, input int c, input int cl);
    int  ex;
    bit  ill, mis, fault;
    if (r != 0) begin
      m_prev_cnt = 0; m_prev_start = 0; m_frames = 0;
      m_in_frame = 0; m_resync = 0;
      m_oh = 0; m_busy = 0; m_done = 0; m_err = 0; m_code = 0;
      return;
    end
    ex    = m_expected();
    ill   = (c > LP);
    mis   = !ill && !m_resync && (c != ex);
    fault = ill || mis;
    m_done = (m_in_frame && !fault && c == 0 && m_prev_cnt == LP) ? 1 : 0;
    if (m_done != 0) m_frames++;
    if (fault) begin
      m_resync = 1; m_in_frame = 0;
    end else if (m_resync) begin
      if (c == 0) m_resync = 0;
    end else if (!m_in_frame) begin
      if (c == 1) m_in_frame = 1;
    end else if (m_done != 0) begin
      m_in_frame = 0;
    end
    m_busy = m_in_frame ? 1 : 0;
    m_oh   = ill ? 0 : (1 << c);
    if (fault) begin
      if (m_err == 0 || cl != 0) m_code = ill ? 2 : 1;
      m_err = 1;
    end else if (cl != 0) begin
      m_err = 0; m_code = 0;
    end
    m_prev_cnt   = c;
    m_prev_start = s;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int r, input int s, input int c, input int cl);
    rst = r[0]; start = s[0]; cnt_in = c[2:0]; clr_err = cl[0];
    @(posedge clk);
    model_update(r, s, c, cl);
    #1;
    check("phase_oh",    32'(phase_oh),   32'(m_oh));
    check("busy",        32'(busy),       32'(m_busy));
    check("frame_done",  32'(frame_done), 32'(m_done));
    check("frame_cnt",   32'(frame_cnt),  32'(m_frames % 256));
    check("frame_cnt_w2", 32'(frame_cnt2), 32'(m_frames % 4));
    check("err",         32'(err),        32'(m_err));
    check("err_code",    32'(err_code),   32'(m_code));
  endtask

  task automatic clean_frame();
    step(0, 1, 0, 0);
    for (int p = 1; p <= LP; p++) step(0, 0, p, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    int busy_cycles;
    rst = 1'b1; start = 1'b0; cnt_in = 3'd0; clr_err = 1'b0;
    model_update(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("reset_outputs", {busy, frame_done, err, err_code, phase_oh, frame_cnt}, 32'd0);
    step(0, 0, 0, 0);

    // Clean frame: busy for LP cycles, one frame_done
    busy_cycles = 0;
    step(0, 1, 0, 0);
    for (int p = 1; p <= LP; p++) begin
      step(0, 0, p, 0);
      busy_cycles += int'(busy);
    end
    step(0, 0, 0, 0);
    check("clean_busy_cycles", 32'(busy_cycles), 32'(LP));
    check("clean_done", {frame_done, err, frame_cnt}, {1'b1, 1'b0, 8'd1});
    step(0, 0, 0, 0);
    check("done_one_pulse", 32'(frame_done), 32'd0);

    // Skipped phase
    step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 0, 2, 0); step(0, 0, 4, 0);
    check("skip_err", {err, err_code, busy, frame_done}, {1'b1, 2'b01, 1'b0, 1'b0});
    step(0, 0, 3, 0);
    check("resync_no_mismatch", {err, err_code}, {1'b1, 2'b01});
    step(0, 0, 0, 0);
    clean_frame();
    check("skip_then_clean_cnt", 32'(frame_cnt), 32'd2);

    // Illegal value mid-frame
    step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 0, 2, 0); step(0, 0, 7, 1);
    check("illegal", {err, err_code, phase_oh}, {1'b1, 2'b10, 8'h00});
    step(0, 0, 0, 0);

    // Clear racing a mismatch, then clear alone
    step(0, 1, 0, 1); step(0, 0, 1, 0); step(0, 0, 3, 1);
    check("clear_race", {err, err_code}, {1'b1, 2'b01});
    step(0, 0, 0, 1);
    check("clear_alone", {err, err_code}, {1'b0, 2'b00});

    // Reset mid-frame
    step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 0, 2, 0); step(1, 0, 3, 0);
    check("midframe_reset", {busy, frame_done, err, err_code, phase_oh, frame_cnt}, 32'd0);
    step(0, 0, 0, 0);
    check("after_reset_no_err", 32'(err), 32'd0);

    // Counter wrap on the 2-bit instance
    for (int f = 0; f < 4; f++) begin
      clean_frame();
      check("wrap_seq", 32'(frame_cnt2), 32'((f + 1) % 4));
    end

    // Start while mid-frame is ignored
    step(0, 1, 0, 0); step(0, 0, 1, 0); step(0, 1, 2, 0); step(0, 0, 3, 0);
    check("start_ignored", {err, busy}, {1'b0, 1'b1});
    step(0, 0, 4, 0); step(0, 0, 5, 0); step(0, 0, 0, 0);

    // Random traffic mostly following the protocol
    for (int i = 0; i < 3000; i++) begin
      int c, s, cl, r;
      if ($urandom_range(0, 99) < 85) begin
        if (m_resync) c = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, LP);
        else c = m_expected();
      end else begin
        c = $urandom_range(0, 7);
      end
      s  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      cl = ($urandom_range(0, 19) == 0) ? 1 : 0;
      r  = ($urandom_range(0, 149) == 0) ? 1 : 0;
      step(r, s, c, cl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
